// File: rtl/rca_byte_serial_ctrl.sv
// Byte-serial multi-byte adder sequencer wrapped around an external
// combinational 8-bit ripple-carry slice.
module rca_byte_serial_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                c_in,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                c_out,
    output logic                ovf,
    output logic                busy
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_reg_q, a_reg_d;
    logic [W-1:0]  b_reg_q, b_reg_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;

    // Slice operands are only live in RUN so the slice sees quiet zeros otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_reg_q[8*idx_q +: 8];
            add_b   = b_reg_q[8*idx_q +: 8];
            add_cin = carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_reg_d = a;
                    b_reg_d = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[8*idx_q +: 8] = add_sum;
                carry_d             = add_cout;
                if (idx_q == LAST) begin
                    c_out_d = add_cout;
                    // Same-sign operands yielding an opposite-sign result.
                    ovf_d   = (a_reg_q[W-1] == b_reg_q[W-1]) &&
                              (add_sum[7] != a_reg_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_reg_q <= '0;
            b_reg_q <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/rca_byte_serial_ctrl.md
Name: rca_byte_serial_ctrl

Overview:
- Multi-byte adder sequencer that sits directly around the team's 8-bit ripple-carry adder slice.
- It accepts wide operands over a valid/ready handshake and drives one byte pair per cycle, plus the carry-in, into the external 8-bit adder.
- Each cycle it captures the slice's byte sum and carry-out.
- After NBYTES cycles it presents the full-width sum, carry-out and signed overflow over an output valid/ready handshake.

Parameters:
- NBYTES, 4, number of 8-bit slices per operand (operand width W = 8*NBYTES); legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  W  operand A.
- b  input  W  operand B.
- c_in  input  1  carry into byte 0.
- add_a  output  8  byte of A driven to the adder slice.
- add_b  output  8  byte of B driven to the adder slice.
- add_cin  output  1  carry driven to the adder slice.
- add_sum  input  8  slice sum (combinational from add_a/add_b/add_cin).
- add_cout  input  1  slice carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  full sum.
- c_out  output  1  final carry-out.
- ovf  output  1  signed overflow of the W-bit add.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset (async, rst=1) forces:
  - state IDLE, idx=0, carry reg=0.
  - a_reg, b_reg, sum, c_out, ovf = 0.
  - out_valid=0, busy=0, in_ready=1 (decoded from state).
- in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE, on edge with in_valid&&in_ready:
  - latch a, b into a_reg, b_reg; carry <= c_in; idx <= 0; sum <= 0.
  - go to RUN.
- IDLE without in_valid: hold; a/b/c_in ignored.
- RUN, combinational drive:
  - add_a = a_reg[8*idx +: 8], add_b = b_reg[8*idx +: 8], add_cin = carry.
  - The slice is combinational and settles within the cycle.
- RUN, each edge:
  - sum[8*idx +: 8] <= add_sum; carry <= add_cout.
  - If idx==NBYTES-1: c_out <= add_cout; ovf <= (a_reg[W-1]==b_reg[W-1]) && (add_sum[7]!=a_reg[W-1]); state <= DONE.
  - Otherwise idx <= idx+1.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Latency: accept edge at cycle 0, RUN for cycles 1..NBYTES, out_valid high from cycle NBYTES+1. Throughput is one add per NBYTES+2 cycles minimum.
- DONE:
  - sum, c_out and ovf are held stable while out_valid=1 and out_ready=0, for unlimited backpressure.
  - On edge with out_ready=1: go to IDLE. sum, c_out and ovf retain their values until the next accept.
  - A new operand cannot be accepted in the same cycle as the result handoff (in_ready=0 in DONE).
- Operand changes on a, b or c_in after acceptance have no effect on the in-flight add.
- NBYTES=1: RUN lasts exactly one cycle; behaviour is otherwise identical.
- Arithmetic: {c_out,sum} = a + b + c_in, exactly modulo 2^(W+1). ovf follows two's-complement rules on the W-bit result.
- Reset mid-RUN or mid-DONE: aborts immediately, no out_valid pulse, all state as reset. The first accept after release behaves normally.
- The idx counter never exceeds NBYTES-1; no wrap occurs inside a transaction.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, c_in=0, out_ready=1 -> add_cin sequence 0,1,0,0 in cycles 1..4; out_valid at cycle 5; sum=0x00000100, c_out=0, ovf=0.
- a=0xFFFFFFFF, b=0x00000000, c_in=1 -> carry ripples through all 4 bytes; sum=0x00000000, c_out=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, c_in=0 -> sum=0x80000000, c_out=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0, c_out=1, ovf=1.
- Hold out_ready=0 for 10 cycles after out_valid -> sum/c_out/ovf stable, in_ready=0, busy=1. Assert out_ready -> IDLE next cycle, in_ready=1. In the same test, toggle a/b during RUN -> no effect on sum.
- Assert rst during RUN cycle 2 -> all outputs at reset values on the async assert, no out_valid. After release, 0x12345678+0x11111111 -> sum=0x23456789.
- NBYTES=1: a=0xFF, b=0x01, c_in=1 -> out_valid at cycle 2, sum=0x01, c_out=1, ovf=0.
